// File: rtl/mul4_seq.sv
// Sequential shift-and-add unsigned multiplier built on a carry-chained sum4 adder.
// Start accepted in IDLE; product and a one-cycle done pulse appear WIDTH cycles later.

module sum4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
endmodule

module mul4_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NS = WIDTH / 4;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic [NS:0]          cy;
  logic                 c;

  assign addend = q_q[0] ? m_q : '0;
  assign cy[0]  = 1'b0;
  assign c      = cy[NS];

  for (genvar i = 0; i < NS; i++) begin : g_sum
    sum4 u_sum4 (
      .x  (acc_q[4*i +: 4]),
      .y  (addend[4*i +: 4]),
      .ci (cy[i]),
      .s  (sum[4*i +: 4]),
      .co (cy[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Right shift of {carry, sum, multiplier} keeps the adder carry in acc's MSB.
        acc_d = {c, sum[WIDTH-1:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          p_d     = {c, sum, q_q[WIDTH-1:1]};
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;
endmodule

// File: tb/tb_mul4_seq.sv
// Directed plus randomized checks of mul4_seq against plain a*b arithmetic and cycle counts.
module tb_mul4_seq;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] p;

  int checks = 0;
  int failures = 0;

  mul4_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation; operands are scrambled every RUN cycle to prove they are not resampled.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit full);
    int n;
    int nbusy;
    int both;
    int exp_p;
    exp_p = int'(ia) * int'(ib);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; nbusy = 0; both = 0;
    while (!done && n < 20) begin
      if (busy) nbusy++;
      if (busy && done) both++;
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      n++;
    end
    check("latency", n, W);
    check("product", p, exp_p);
    if (full) begin
      check("busy_cycles", nbusy, W);
      check("busy_at_done", busy, 0);
      check("busy_and_done", both, 0);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    if (full) check("p_held", p, exp_p);
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_p", p, 0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset mid-cycle clears a nonzero product without a clock edge.
    do_op(4'd5, 4'd3, 1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_p", p, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    do_op(4'd15, 4'd15, 1'b1);
    do_op(4'd0, 4'd9, 1'b1);
    do_op(4'd9, 4'd0, 1'b1);
    do_op(4'd1, 4'd13, 1'b1);
    do_op(4'd8, 4'd2, 1'b1);

    // A second start while busy is dropped.
    @(negedge clk);
    a = 4'd3; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd7; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        dn++;
        check("ignored_start_p", p, 15);
      end
      @(negedge clk);
    end
    check("ignored_start_dones", dn, 1);
    check("ignored_start_busy", busy, 0);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    a = 4'd6; b = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_p", p, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);
    check("abort_p_after", p, 0);
    do_op(4'd6, 4'd7, 1'b1);

    for (int i = 0; i < 30; i++) do_op(W'($urandom), W'($urandom), 1'b1);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        do_op(W'(ia), W'(ib), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
